// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the shared data-memory port: LSU (port 0) has priority,
// DMA (port 1) gets a bounded wait, and every access is alignment/range checked.
module dmem_arbiter #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int MEM_BYTES     = 131072,
    parameter int MAX_WAIT      = 8
) (
    input  logic                     clk,
    input  logic                     rst,

    input  logic                     p0_valid,
    output logic                     p0_ready,
    input  logic                     p0_we,
    input  logic [ADDRESS_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0]    p0_wdata,
    input  logic [2:0]               p0_funct3,
    output logic                     p0_resp_valid,
    output logic [DATA_WIDTH-1:0]    p0_resp_rdata,
    output logic                     p0_resp_err,

    input  logic                     p1_valid,
    output logic                     p1_ready,
    input  logic                     p1_we,
    input  logic [ADDRESS_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0]    p1_wdata,
    input  logic [2:0]               p1_funct3,
    output logic                     p1_resp_valid,
    output logic [DATA_WIDTH-1:0]    p1_resp_rdata,
    output logic                     p1_resp_err,

    output logic                     mem_wr_en,
    output logic [ADDRESS_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]    mem_wdata,
    output logic [2:0]               mem_funct3,
    input  logic [DATA_WIDTH-1:0]    mem_rdata
);

    localparam logic [ADDRESS_WIDTH:0] MEM_LIMIT  = (ADDRESS_WIDTH+1)'(MEM_BYTES);
    localparam logic [7:0]             WAIT_LIMIT = 8'(MAX_WAIT);

    logic [7:0]            wait_q, wait_d;
    logic                  grant0, grant1;
    logic                  xfer0, xfer1, xfer;
    logic                  sel_we;
    logic [ADDRESS_WIDTH:0] size_ext, end_addr;
    logic                  misaligned, out_of_range, acc_err;

    logic                  p0_rv_d, p0_rv_q, p1_rv_d, p1_rv_q;
    logic                  p0_err_d, p0_err_q, p1_err_d, p1_err_q;
    logic [DATA_WIDTH-1:0] p0_rdata_d, p0_rdata_q, p1_rdata_d, p1_rdata_q;

    // Grant depends only on the valids and the wait counter, never on address or data.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (p0_valid && p1_valid) begin
            if (wait_q == WAIT_LIMIT) grant1 = 1'b1;
            else                      grant0 = 1'b1;
        end else if (p0_valid) begin
            grant0 = 1'b1;
        end else if (p1_valid) begin
            grant1 = 1'b1;
        end
    end

    assign p0_ready = grant0 && !rst;
    assign p1_ready = grant1 && !rst;
    assign xfer0    = p0_valid && p0_ready;
    assign xfer1    = p1_valid && p1_ready;
    assign xfer     = xfer0 || xfer1;

    always_comb begin
        sel_we     = p0_we;
        mem_addr   = p0_addr;
        mem_wdata  = p0_wdata;
        mem_funct3 = p0_funct3;
        if (grant1) begin
            sel_we     = p1_we;
            mem_addr   = p1_addr;
            mem_wdata  = p1_wdata;
            mem_funct3 = p1_funct3;
        end
    end

    // The end address is one bit wider so that wrap-around past the top counts as out of range.
    always_comb begin
        case (mem_funct3[1:0])
            2'b00:   size_ext = (ADDRESS_WIDTH+1)'(1);
            2'b01:   size_ext = (ADDRESS_WIDTH+1)'(2);
            default: size_ext = (ADDRESS_WIDTH+1)'(4);
        endcase
        misaligned   = ((mem_funct3[1:0] == 2'b01) && mem_addr[0])
                    || (mem_funct3[1] && (mem_addr[1:0] != 2'b00));
        end_addr     = {1'b0, mem_addr} + size_ext;
        out_of_range = end_addr > MEM_LIMIT;
        acc_err      = misaligned || out_of_range;
    end

    assign mem_wr_en = xfer && sel_we && !acc_err;

    always_comb begin
        wait_d = wait_q;
        if (xfer1) begin
            wait_d = 8'd0;
        end else if (p1_valid && (wait_q < WAIT_LIMIT)) begin
            wait_d = wait_q + 8'd1;
        end
    end

    always_comb begin
        p0_rv_d    = xfer0;
        p1_rv_d    = xfer1;
        p0_err_d   = xfer0 && acc_err;
        p1_err_d   = xfer1 && acc_err;
        p0_rdata_d = (xfer0 && !sel_we && !acc_err) ? mem_rdata : '0;
        p1_rdata_d = (xfer1 && !sel_we && !acc_err) ? mem_rdata : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_q     <= 8'd0;
            p0_rv_q    <= 1'b0;
            p1_rv_q    <= 1'b0;
            p0_err_q   <= 1'b0;
            p1_err_q   <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else begin
            wait_q     <= wait_d;
            p0_rv_q    <= p0_rv_d;
            p1_rv_q    <= p1_rv_d;
            p0_err_q   <= p0_err_d;
            p1_err_q   <= p1_err_d;
            p0_rdata_q <= p0_rdata_d;
            p1_rdata_q <= p1_rdata_d;
        end
    end

    assign p0_resp_valid = p0_rv_q;
    assign p1_resp_valid = p1_rv_q;
    assign p0_resp_err   = p0_err_q;
    assign p1_resp_err   = p1_err_q;
    assign p0_resp_rdata = p0_rdata_q;
    assign p1_resp_rdata = p1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and sequencer for the byte-addressed data memory. It shares the single data-memory access port between the CPU load/store unit (port 0) and a DMA/loader master (port 1). Each access gets an alignment and range check, and read data returns on a registered one-cycle response. It sits between the execute/memory stage plus the DMA engine on one side and the data memory on the other. The DMA port has a bounded-starvation guarantee.

## Interface
Parameters:
- ADDRESS_WIDTH, 32, address width on all ports
- DATA_WIDTH, 32, data width on all ports
- MEM_BYTES, 131072, size of the memory in bytes; accesses ending at or beyond this are range errors
- MAX_WAIT, 8, maximum cycles port 1 may wait while port 0 holds priority; valid range 1..255

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- p0_valid, p1_valid  in  1  request valid
- p0_ready, p1_ready  out  1  request accepted this cycle (combinational)
- p0_we, p1_we  in  1  1 = store, 0 = load
- p0_addr, p1_addr  in  ADDRESS_WIDTH  byte address
- p0_wdata, p1_wdata  in  DATA_WIDTH  store data
- p0_funct3, p1_funct3  in  3  RV32 size/sign code
- p0_resp_valid, p1_resp_valid  out  1  one-cycle response strobe
- p0_resp_rdata, p1_resp_rdata  out  DATA_WIDTH  load data; 0 for stores and errors
- p0_resp_err, p1_resp_err  out  1  misaligned or out-of-range access
- mem_wr_en  out  1  memory write enable
- mem_addr  out  ADDRESS_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory store data
- mem_funct3  out  3  memory size/sign code
- mem_rdata  in  DATA_WIDTH  combinational memory read data

## Operation
- **Transfer rule.** A transfer occurs on port k when pk_valid && pk_ready. At most one port is ready per cycle.
- **Grant.**
  - Only one port valid: that port is granted.
  - Both ports valid: port 0 is granted, unless wait_cnt == MAX_WAIT, in which case port 1 is granted.
- **wait_cnt (8-bit).**
  - Increments, saturating at MAX_WAIT, on each cycle p1_valid is high and port 1 is not granted.
  - Cleared on every port-1 transfer.
- **Memory mux.** mem_addr, mem_wdata and mem_funct3 follow the granted port. When no port is granted they follow port 0.
- **Size.** Decoded from funct3[1:0]: 00 = 1 byte, 01 = 2 bytes, 10/11 = 4 bytes. funct3 is otherwise passed through unchanged.
- **Error.** An access is an error if either:
  - it is misaligned: half with addr[0] = 1, or word with addr[1:0] != 0; or
  - it is out of range: addr + size > MEM_BYTES. This sum is computed in ADDRESS_WIDTH+1 bits, so wrap-around is an error.
- **Error handling.** An errored access is still accepted. No memory side effect occurs (mem_wr_en stays 0). The response carries err = 1 and rdata = 0.
- **Writes.** mem_wr_en = transfer && we && !err. Memory commits on the same rising edge.
- **Reads.** On a load transfer, mem_rdata is captured into the granted port's resp_rdata register at the end of the transfer cycle.
- **Response.** resp_valid is asserted on the next cycle for exactly one cycle, for loads and stores alike.

## Timing
- **Reset values.** While rst is high:
  - All resp_valid, resp_err and resp_rdata are 0.
  - wait_cnt is 0.
  - p0_ready, p1_ready and mem_wr_en are forced to 0.
- **Reset mid-operation.** rst asserted mid-operation drops any pending response. No response is issued after reset releases.
- **Latency.**
  - Request to response: 1 cycle.
  - Throughput: one transfer per cycle, total across both ports.
- **Back-to-back responses.** Back-to-back transfers on the same port give resp_valid high on consecutive cycles, each with its own data.
- **Store then load to the same address.** A store at cycle N followed by a load at cycle N+1 to the same address returns the stored data. Memory is written at the edge ending cycle N.
- **Ready independence.** pk_ready depends only on the valid inputs and wait_cnt. It never depends on addr or data, so there is no combinational path from mem_rdata to ready.
- **Starvation bound.** Under continuous port-0 traffic, port 1 is granted within MAX_WAIT+1 cycles of raising p1_valid.
- **Request stability.** The requester must hold its request stable while valid && !ready. Dropping valid before acceptance is allowed. wait_cnt keeps its value until the next port-1 transfer.

## Test plan
- **Reset.** Assert rst for 3 cycles with both valids high -> ready = 0, mem_wr_en = 0, all resp outputs 0. After release, port 0 is granted on the first cycle.
- **Port-0 store/load.** Port 0 stores 0xDEADBEEF at 0x10000 (funct3 010), then loads it back -> mem_wr_en pulses once; p0_resp_valid on cycles N+1 and N+2; load rdata = 0xDEADBEEF with err = 0.
- **Contention.** p0_valid and p1_valid both held high with MAX_WAIT = 8 -> port 0 granted for 8 cycles, port 1 granted on cycle 9, wait_cnt returns to 0, then port 0 granted again. Repeats with period 9.
- **Alignment errors.** Half load at 0x10001 and word store at 0x10002 -> resp_err = 1, rdata = 0, mem_wr_en stays 0, memory unchanged.
- **Range errors.** Word load at 0x1FFFC -> err = 0. Word load at 0x1FFFD -> err = 1. Byte access at 0xFFFFFFFF -> err = 1.
- **Reset mid-transfer.** Port-1 load accepted, then rst asserted before the response cycle -> p1_resp_valid never asserts for that load.
